// File: rtl/bin_to_seg_display_if.sv
// Interface between a value source and the seven-segment converter.
// Master drives load/value/lz_blank/blink_en; slave returns busy/done/overflow/hex.
interface bin_to_seg_display_if #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
);
  logic                  load;
  logic [WIDTH-1:0]      value;
  logic                  lz_blank;
  logic                  blink_en;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [DIGITS*7-1:0]   hex;

  modport master (
    output load, value, lz_blank, blink_en,
    input  busy, done, overflow, hex
  );

  modport slave (
    input  load, value, lz_blank, blink_en,
    output busy, done, overflow, hex
  );
endinterface

// File: rtl/bin_to_seg_display.sv
// Binary to multi-digit seven-segment driver: double-dabble, one bit per cycle, WIDTH+2 cycles load->display.
// load is ignored while busy; the display stays double-buffered until the conversion completes.
module bin_to_seg_display #(
  parameter int WIDTH     = 14,
  parameter int DIGITS    = 4,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bin_to_seg_display_if.slave   bus
);

  localparam int BCDW = 4 * DIGITS;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int BW   = $clog2(BLINK_DIV);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [63:0] max_disp(input int n);
    logic [63:0] m;
    m = 64'd1;
    for (int i = 0; i < n; i++) m = m * 64'd10;
    return m - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_disp(DIGITS);

  function automatic logic [6:0] seg(input logic [3:0] nib);
    case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [BCDW-1:0]     bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                lzb_q, lzb_d;
  logic                ovfp_q, ovfp_d;
  logic [DIGITS*7-1:0] disp_q, disp_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic                phase_q, phase_d;

  logic [BCDW-1:0]     bcd_adj;
  logic [DIGITS*7-1:0] disp_next;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Leading-zero blanking stops at the highest nonzero digit; digit 0 always shows.
  always_comb begin
    int msd;
    msd       = 0;
    disp_next = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msd = i;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (ovfp_q)                disp_next[7*i +: 7] = SEG_DASH;
      else if (lzb_q && i > msd) disp_next[7*i +: 7] = SEG_BLANK;
      else                       disp_next[7*i +: 7] = seg(bcd_q[4*i +: 4]);
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    lzb_d   = lzb_q;
    ovfp_d  = ovfp_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          shreg_d = bus.value;
          lzb_d   = bus.lz_blank;
          ovfp_d  = (64'(bus.value) > MAX_VAL);
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Bits carried out of the top nibble are dropped; overflow was already decided at capture.
        bcd_d   = (bcd_adj << 1) | BCDW'(shreg_q[WIDTH-1]);
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = UPDATE;
      end
      UPDATE: begin
        disp_d  = disp_next;
        ovf_d   = ovfp_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bcnt_d  = bcnt_q + 1'b1;
    phase_d = phase_q;
    if (bcnt_q == BW'(BLINK_DIV - 1)) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      lzb_q   <= 1'b0;
      ovfp_q  <= 1'b0;
      disp_q  <= '1;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      lzb_q   <= lzb_d;
      ovfp_q  <= ovfp_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.hex      = (bus.blink_en && phase_q) ? '1 : disp_q;

endmodule

// File: tb/tb_bin_to_seg_display.sv
// Bench for bin_to_seg_display: vector table through a done-driven scoreboard,
// plus hand-written sequences for ignored load, blink and mid-conversion reset.
module tb_bin_to_seg_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000, DS = 7'b0111111, BL = 7'b1111111;
  localparam logic [27:0] ONES = 28'hFFFFFFF;
  localparam logic [27:0] P42  = {BL, BL, S4, S2};
  localparam logic [27:0] P1234 = {S1, S2, S3, S4};

  typedef struct {
    logic [13:0] v;
    logic        lz;
    logic [27:0] hex;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [27:0] hex;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  exp_t sb[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  bin_to_seg_display_if #(.WIDTH(14), .DIGITS(4)) bus ();

  bin_to_seg_display #(.WIDTH(14), .DIGITS(4), .BLINK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done: got hex=%h expected no done pulse", bus.hex);
      end else begin
        e = sb.pop_front();
        check("sb_hex", 64'(bus.hex), 64'(e.hex));
        check("sb_ovf", 64'(bus.overflow), 64'(e.ovf));
      end
    end
  end

  task automatic convert(input logic [13:0] v, input logic lz, input logic [27:0] eh, input logic eo);
    int   cyc;
    logic got;
    logic busy_all;
    exp_t e;
    @(negedge clk);
    bus.load = 1'b1; bus.value = v; bus.lz_blank = lz;
    e.hex = eh; e.ovf = eo;
    sb.push_back(e);
    @(posedge clk); #1;
    check("busy_after_load", 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.load = 1'b0;
    cyc = 0; got = 1'b0; busy_all = 1'b1;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done === 1'b1) got = 1'b1;
      else if (bus.busy !== 1'b1) busy_all = 1'b0;
    end
    check("done_latency", 64'(cyc), 64'd15);
    check("busy_held", 64'(busy_all), 64'd1);
    check("busy_fall", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic [27:0] s[17];
    logic [27:0] a, b, expv;
    int k, d0, n;

    vecs[0] = '{14'd1234,  1'b0, {S1, S2, S3, S4}, 1'b0};
    vecs[1] = '{14'd7,     1'b1, {BL, BL, BL, S7}, 1'b0};
    vecs[2] = '{14'd0,     1'b1, {BL, BL, BL, S0}, 1'b0};
    vecs[3] = '{14'd0,     1'b0, {S0, S0, S0, S0}, 1'b0};
    vecs[4] = '{14'd10000, 1'b0, {DS, DS, DS, DS}, 1'b1};
    vecs[5] = '{14'd9999,  1'b0, {S9, S9, S9, S9}, 1'b0};
    vecs[6] = '{14'd16383, 1'b1, {DS, DS, DS, DS}, 1'b1};
    vecs[7] = '{14'd405,   1'b1, {BL, S4, S0, S5}, 1'b0};
    vecs[8] = '{14'd1000,  1'b1, {S1, S0, S0, S0}, 1'b0};
    vecs[9] = '{14'd42,    1'b1, P42, 1'b0};

    bus.load = 1'b0; bus.value = '0; bus.lz_blank = 1'b0; bus.blink_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hex", 64'(bus.hex), 64'(ONES));
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) convert(vecs[i].v, vecs[i].lz, vecs[i].hex, vecs[i].ovf);

    // A second load mid-conversion must be dropped.
    @(negedge clk);
    bus.load = 1'b1; bus.value = 14'd1234; bus.lz_blank = 1'b0;
    sb.push_back('{P1234, 1'b0});
    d0 = done_cnt;
    @(posedge clk);
    @(negedge clk);
    bus.load = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.load = 1'b1; bus.value = 14'd5678;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("ignored_load_dones", 64'(done_cnt - d0), 64'd1);
    check("ignored_load_hex", 64'(bus.hex), 64'(P1234));

    convert(14'd42, 1'b1, P42, 1'b0);
    @(negedge clk);
    bus.blink_en = 1'b1;
    for (int j = 0; j < 17; j++) begin
      @(posedge clk); #1;
      s[j] = bus.hex;
    end
    k = 0;
    for (int j = 1; j <= 4; j++) if (k == 0 && s[j] != s[j-1]) k = j;
    check("blink_toggles", 64'(k != 0), 64'd1);
    if (k == 0) k = 1;
    a = s[k-1]; b = s[k];
    check("blink_values", 64'((a == P42 && b == ONES) || (a == ONES && b == P42)), 64'd1);
    for (int j = k; j < k + 12; j++) begin
      expv = ((((j - k) / 4) % 2) == 0) ? b : a;
      check("blink_period", 64'(s[j]), 64'(expv));
    end
    n = 0;
    while (bus.hex !== ONES && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("blink_dark_seen", 64'(bus.hex), 64'(ONES));
    bus.blink_en = 1'b0;
    #1;
    check("blink_off_immediate", 64'(bus.hex), 64'(P42));
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      check("blink_off_steady", 64'(bus.hex), 64'(P42));
    end

    // Reset in the middle of a conversion.
    @(negedge clk);
    bus.load = 1'b1; bus.value = 14'd99; bus.lz_blank = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.load = 1'b0;
    repeat (7) @(posedge clk);
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_hex", 64'(bus.hex), 64'(ONES));
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    check("midrst_still_blank", 64'(bus.hex), 64'(ONES));
    convert(14'd99, 1'b1, {BL, BL, S9, S9}, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
